// File: rtl/tmds_pkg.sv
// Shared TMDS constants and helpers: control codes, depth expansion and ones count.
package tmds_pkg;

  localparam logic [9:0] CTRL_00    = 10'b1101010100;
  localparam logic [9:0] CTRL_01    = 10'b0010101011;
  localparam logic [9:0] CTRL_10    = 10'b0101010100;
  localparam logic [9:0] CTRL_11    = 10'b1010101011;
  localparam logic [9:0] RESET_CODE = CTRL_00;

  // v holds the colour value right-aligned; its MSB-first bit pattern is repeated into 8 bits.
  function automatic logic [7:0] expand_depth(input logic [7:0] v, input int depth);
    logic [7:0] r;
    int src;
    int dst;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      src = depth - 1 - (i % depth);
      dst = 7 - i;
      r[dst[2:0]] = v[src[2:0]];
    end
    return r;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] x);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, x[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/vga2tmds_encoder_if.sv
// Video bundle between a pixel source and the TMDS encoder: VGA-style inputs, three TMDS words out.
interface vga2tmds_encoder_if #(
  parameter int C_depth = 3
) ();
  logic [C_depth-1:0] in_red;
  logic [C_depth-1:0] in_green;
  logic [C_depth-1:0] in_blue;
  logic               in_hsync;
  logic               in_vsync;
  logic               in_blank;
  logic [9:0]         out_red;
  logic [9:0]         out_green;
  logic [9:0]         out_blue;

  modport master (
    output in_red, in_green, in_blue, in_hsync, in_vsync, in_blank,
    input  out_red, out_green, out_blue
  );

  modport slave (
    input  in_red, in_green, in_blue, in_hsync, in_vsync, in_blank,
    output out_red, out_green, out_blue
  );
endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: transition-minimising stage A, DC-balancing stage B with its
// running disparity counter, and control-code insertion while blanked.
module tmds_channel_encoder
  import tmds_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic [1:0] c,
  input  logic       blank,
  output logic [9:0] out
);

  function automatic logic [8:0] stage_a(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0]        qm_q;
  logic [1:0]        c_q;
  logic              blank_q;
  logic [9:0]        out_q, out_d;
  logic signed [5:0] cnt_q, cnt_d;

  logic [3:0]        n1_b;
  logic signed [5:0] diff_b;     // N1 - N0 of q_m[7:0]
  logic signed [5:0] two_q8_b;
  logic signed [5:0] two_nq8_b;

  assign n1_b      = ones8(qm_q[7:0]);
  assign diff_b    = $signed({1'b0, n1_b, 1'b0}) - 6'sd8;
  assign two_q8_b  = $signed({3'b000, qm_q[8], 1'b0});
  assign two_nq8_b = $signed({3'b000, ~qm_q[8], 1'b0});

  always_comb begin
    out_d = RESET_CODE;
    cnt_d = cnt_q;
    if (blank_q) begin
      cnt_d = 6'sd0;
      unique case (c_q)
        2'b00:   out_d = CTRL_00;
        2'b01:   out_d = CTRL_01;
        2'b10:   out_d = CTRL_10;
        default: out_d = CTRL_11;
      endcase
    end else if ((cnt_q == 6'sd0) || (diff_b == 6'sd0)) begin
      out_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d = qm_q[8] ? (cnt_q + diff_b) : (cnt_q - diff_b);
    end else if (((cnt_q > 6'sd0) && (diff_b > 6'sd0)) ||
                 ((cnt_q < 6'sd0) && (diff_b < 6'sd0))) begin
      out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d = cnt_q + two_q8_b - diff_b;
    end else begin
      out_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d = cnt_q + diff_b - two_nq8_b;
    end
  end

  // Reset leaves stage A looking blanked so no half-encoded word leaks out afterwards.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      qm_q    <= '0;
      c_q     <= 2'b00;
      blank_q <= 1'b1;
      out_q   <= RESET_CODE;
      cnt_q   <= 6'sd0;
    end else begin
      qm_q    <= stage_a(data);
      c_q     <= c;
      blank_q <= blank;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/vga2tmds_encoder.sv
// VGA RGB of 1..8 bits per colour to three TMDS words per pixel; optional input
// register, depth expansion and blank polarity normalisation ahead of the channel encoders.
module vga2tmds_encoder
  import tmds_pkg::*;
#(
  parameter int C_depth             = 3,
  parameter int C_register_input    = 1,
  parameter int C_blank_active_high = 1
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [C_depth-1:0] in_red,
  input  logic [C_depth-1:0] in_green,
  input  logic [C_depth-1:0] in_blue,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_blank,
  output logic [9:0]         out_red,
  output logic [9:0]         out_green,
  output logic [9:0]         out_blue
);

  logic               blank_norm;
  logic [C_depth-1:0] red_s, green_s, blue_s;
  logic               hsync_s, vsync_s, blank_s;

  assign blank_norm = (C_blank_active_high != 0) ? in_blank : ~in_blank;

  generate
    if (C_register_input != 0) begin : g_in_reg
      logic [C_depth-1:0] red_q, green_q, blue_q;
      logic               hsync_q, vsync_q, blank_q;

      always_ff @(posedge clk_pixel) begin
        if (reset) begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
          hsync_q <= 1'b0;
          vsync_q <= 1'b0;
          blank_q <= 1'b1;
        end else begin
          red_q   <= in_red;
          green_q <= in_green;
          blue_q  <= in_blue;
          hsync_q <= in_hsync;
          vsync_q <= in_vsync;
          blank_q <= blank_norm;
        end
      end

      assign red_s   = red_q;
      assign green_s = green_q;
      assign blue_s  = blue_q;
      assign hsync_s = hsync_q;
      assign vsync_s = vsync_q;
      assign blank_s = blank_q;
    end else begin : g_in_direct
      assign red_s   = in_red;
      assign green_s = in_green;
      assign blue_s  = in_blue;
      assign hsync_s = in_hsync;
      assign vsync_s = in_vsync;
      assign blank_s = blank_norm;
    end
  endgenerate

  logic [7:0] red_w, green_w, blue_w;
  logic [7:0] chan_data [3];
  logic [1:0] chan_ctrl [3];
  logic [9:0] chan_out  [3];

  // Channel index follows TMDS numbering: 0 blue (carries syncs), 1 green, 2 red.
  always_comb begin
    red_w                  = '0;
    green_w                = '0;
    blue_w                 = '0;
    red_w[C_depth-1:0]     = red_s;
    green_w[C_depth-1:0]   = green_s;
    blue_w[C_depth-1:0]    = blue_s;
    chan_data[0]           = expand_depth(blue_w, C_depth);
    chan_data[1]           = expand_depth(green_w, C_depth);
    chan_data[2]           = expand_depth(red_w, C_depth);
    chan_ctrl[0]           = {vsync_s, hsync_s};
    chan_ctrl[1]           = 2'b00;
    chan_ctrl[2]           = 2'b00;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      tmds_channel_encoder u_enc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .data      (chan_data[gi]),
        .c         (chan_ctrl[gi]),
        .blank     (blank_s),
        .out       (chan_out[gi])
      );
    end
  endgenerate

  assign out_blue  = chan_out[0];
  assign out_green = chan_out[1];
  assign out_red   = chan_out[2];

endmodule
